// File: rtl/adc_ddr_tx_pkg.sv
// ----------------------------------------------------------------------------
// adc_ddr_tx_pkg
// Definitions shared between the ADC DDR transmitter and the LVDS capture
// front end. These are the lane count and width, the default idle word pair,
// the packed word-pair type and the output-source selector.
// Ports: none (package).
// ----------------------------------------------------------------------------
package adc_ddr_tx_pkg;

    localparam int ADC_LANES = 6;
    localparam int LANE_W    = 6;
    localparam int PAIR_W    = 2 * LANE_W;

    localparam logic [LANE_W-1:0] IDLE_A_DEF = 6'h2A;
    localparam logic [LANE_W-1:0] IDLE_B_DEF = 6'h15;

    typedef logic [LANE_W-1:0] lane_t;

    // chA sits in the upper half so {a, b} lines up with the lane ordering.
    typedef struct packed {
        lane_t a;
        lane_t b;
    } pair_t;

    // Selects what the output register loads on each dclk edge.
    typedef enum logic [1:0] {
        SRC_OFF  = 2'd0,
        SRC_FIFO = 2'd1,
        SRC_IDLE = 2'd2
    } src_e;

endpackage

// File: rtl/adc_tx_fifo.sv
// ----------------------------------------------------------------------------
// adc_tx_fifo
// Synchronous word-pair FIFO. The pointers are log2(DEPTH)+1 bits wide and
// wrap naturally. The head entry is always presented on o_rdata, and the
// consumer registers it in the same edge that pops it.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push/i_wdata write one entry (caller guarantees not full)
//   i_pop          advance the head (caller guarantees not empty)
//   o_rdata        head entry
//   o_level        occupancy 0..DEPTH
//   o_full/o_empty status flags
// ----------------------------------------------------------------------------
module adc_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Full: the wrap bits differ while the index bits match.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/adc_ddr_tx.sv
// ----------------------------------------------------------------------------
// adc_ddr_tx
// ADC emulator / loopback source. It buffers chA/chB word pairs and drives
// them onto DDR LVDS lanes with a forwarded clock. chA goes out in the high
// phase of dclk and chB in the low phase. When the FIFO is empty and tx_en=1,
// the idle pair is sent and underflow_cnt counts the cycle.
// Optional feature macro: ADC_TX_RAMP_EN. When it is defined, a 12-bit ramp
// replaces the idle constants.
// Ports:
//   dclk, rst          transmit clock, asynchronous active-high reset
//   tx_en              1 = transmit, 0 = lanes 0 and FIFO held
//   s_dat_a/b, s_valid, s_ready   word-pair input stream
//   d_p/d_n            DDR data lanes
//   clk_p/clk_n        forwarded clock
//   level              FIFO occupancy
//   underflow_cnt      saturating count of idle cycles while tx_en=1
// Handshake: a pair transfers on a dclk edge where s_valid && s_ready. s_valid
// is not required to wait for s_ready, and s_ready does not depend on s_valid.
// ----------------------------------------------------------------------------
module adc_ddr_tx
    import adc_ddr_tx_pkg::*;
#(
    parameter int                DEPTH  = 16,
    parameter logic [LANE_W-1:0] IDLE_A = IDLE_A_DEF,
    parameter logic [LANE_W-1:0] IDLE_B = IDLE_B_DEF
) (
    input  logic                   dclk,
    input  logic                   rst,
    input  logic                   tx_en,
    input  logic [LANE_W-1:0]      s_dat_a,
    input  logic [LANE_W-1:0]      s_dat_b,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [ADC_LANES-1:0]   d_p,
    output logic [ADC_LANES-1:0]   d_n,
    output logic                   clk_p,
    output logic                   clk_n,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            underflow_cnt
);

    // Reset asserts asynchronously and releases on the second dclk edge.
    logic [1:0] r_rst_sync;
    logic       w_rst;

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    logic  w_push;
    logic  w_pop;
    logic  w_full;
    logic  w_empty;
    pair_t w_fifo_rdata;
    pair_t w_idle;
    pair_t w_next;
    src_e  w_src;

    assign s_ready = ~w_rst & ~w_full;
    assign w_push  = s_valid & s_ready;
    assign w_pop   = (w_src == SRC_FIFO);

    adc_tx_fifo #(
        .DEPTH (DEPTH),
        .W     (PAIR_W)
    ) u_fifo (
        .i_clk   (dclk),
        .i_rst   (w_rst),
        .i_push  (w_push),
        .i_wdata ({s_dat_a, s_dat_b}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_src = SRC_OFF;
        if (tx_en) begin
            w_src = w_empty ? SRC_IDLE : SRC_FIFO;
        end
    end

`ifdef ADC_TX_RAMP_EN
    localparam logic [PAIR_W-1:0] RAMP_ONE = 1;
    logic [PAIR_W-1:0] r_ramp;

    // The ramp advances only when a ramp word is actually sent.
    always_ff @(posedge dclk or posedge w_rst) begin
        if (w_rst) begin
            r_ramp <= '0;
        end else if (w_src == SRC_IDLE) begin
            r_ramp <= r_ramp + RAMP_ONE;
        end
    end

    assign w_idle = r_ramp;
`else
    assign w_idle = {IDLE_A, IDLE_B};
`endif

    always_comb begin
        w_next = '0;
        case (w_src)
            SRC_FIFO: w_next = w_fifo_rdata;
            SRC_IDLE: w_next = w_idle;
            default:  w_next = '0;
        endcase
    end

    // Output register {a_q, b_q} and the underflow counter.
    pair_t       r_pair_q;
    logic [15:0] r_underflow;

    always_ff @(posedge dclk or posedge w_rst) begin
        if (w_rst) begin
            r_pair_q    <= '0;
            r_underflow <= '0;
        end else begin
            r_pair_q <= w_next;
            if ((w_src == SRC_IDLE) && (r_underflow != 16'hFFFF)) begin
                r_underflow <= r_underflow + 16'd1;
            end
        end
    end

    assign underflow_cnt = r_underflow;

    // DDR output cells (SAME_EDGE): both halves are captured on the rising
    // edge, D1 is driven in the high phase and D2 in the low phase. Their
    // reset pulls the lanes to 0 without waiting for a clock.
    lane_t r_ddr_d1;
    lane_t r_ddr_d2;
    logic  r_fwd_d1;

    always_ff @(posedge dclk or posedge w_rst) begin
        if (w_rst) begin
            r_ddr_d1 <= '0;
            r_ddr_d2 <= '0;
            r_fwd_d1 <= 1'b0;
        end else begin
            r_ddr_d1 <= r_pair_q.a;
            r_ddr_d2 <= r_pair_q.b;
            r_fwd_d1 <= 1'b1;
        end
    end

    // Differential buffers: the n leg is the complement of the p leg.
    assign d_p   = dclk ? r_ddr_d1 : r_ddr_d2;
    assign d_n   = ~d_p;
    assign clk_p = dclk & r_fwd_d1;
    assign clk_n = ~clk_p;

endmodule

// File: tb/tb_adc_ddr_tx.sv
module tb_adc_ddr_tx;
    import adc_ddr_tx_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

`ifdef ADC_TX_RAMP_EN
    localparam logic [11:0] ID0 = 12'h000;
    localparam logic [11:0] ID1 = 12'h001;
    localparam logic [11:0] ID2 = 12'h002;
`else
    localparam logic [11:0] ID0 = {6'h2A, 6'h15};
    localparam logic [11:0] ID1 = {6'h2A, 6'h15};
    localparam logic [11:0] ID2 = {6'h2A, 6'h15};
`endif

    // ---------------- clock / reset ----------------
    logic          dclk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_en = 1'b0;
    logic          s_valid = 1'b0;
    logic [5:0]    s_dat_a = '0;
    logic [5:0]    s_dat_b = '0;
    logic          s_ready;
    logic [5:0]    d_p;
    logic [5:0]    d_n;
    logic          clk_p;
    logic          clk_n;
    logic [LW-1:0] level;
    logic [15:0]   underflow_cnt;

    always #5 dclk = ~dclk;

    adc_ddr_tx #(.DEPTH(DEPTH)) dut (
        .dclk          (dclk),
        .rst           (rst),
        .tx_en         (tx_en),
        .s_dat_a       (s_dat_a),
        .s_dat_b       (s_dat_b),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .d_p           (d_p),
        .d_n           (d_n),
        .clk_p         (clk_p),
        .clk_n         (clk_n),
        .level         (level),
        .underflow_cnt (underflow_cnt)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [11:0] exp_q[$];
    logic [11:0] m_fifo[$];
    logic [15:0] m_uf;
    logic [11:0] m_ramp;
    logic [11:0] last_obs;
    logic [LW-1:0] last_level;

    typedef struct {
        logic        en;
        logic        v;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [11:0] exp;
        int          lvl;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        exp_q.push_back(12'h000);
        m_uf   = '0;
        m_ramp = '0;
    endtask

    // Asserts reset, checks the reset state, then releases it and returns at
    // posedge-3 with the first post-reset edge still ahead.
    task automatic do_reset();
        logic ok;
        rst     = 1'b1;
        tx_en   = 1'b0;
        s_valid = 1'b0;
        @(posedge dclk); #2;
        check("rst_level", 32'(level), 0);
        check("rst_ready", 32'(s_ready), 0);
        check("rst_lanes", 32'(d_p), 0);
        check("rst_uf", 32'(underflow_cnt), 0);
        @(negedge dclk); #2;
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge dclk); #2;
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("ready_after_reset", 32'(ok), 1);
        check("post_rst_uf", 32'(underflow_cnt), 0);
        @(negedge dclk); #2;
        model_reset();
    endtask

    // One dclk cycle. It drives the inputs, steps the model, then captures the
    // DDR pins (chA in the high phase, chB in the low phase) and compares them.
    task automatic cycle(input logic en, input logic v, input logic [5:0] a, input logic [5:0] b);
        logic [11:0] nxt;
        logic [11:0] exp;
        logic [5:0]  obs_a;
        logic [5:0]  obs_b;
        logic [5:0]  inv;
        logic        acc;
        tx_en   = en;
        s_valid = v;
        s_dat_a = a;
        s_dat_b = b;
        check("s_ready", 32'(s_ready), 32'(m_fifo.size() < DEPTH));
        acc = v && s_ready;
        if (!en) begin
            nxt = '0;
        end else if (m_fifo.size() > 0) begin
            nxt = m_fifo.pop_front();
        end else begin
`ifdef ADC_TX_RAMP_EN
            nxt    = m_ramp;
            m_ramp = m_ramp + 12'd1;
`else
            nxt = {6'h2A, 6'h15};
`endif
            if (m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
        end
        if (acc) m_fifo.push_back({a, b});
        exp_q.push_back(nxt);

        @(posedge dclk); #2;
        obs_a = d_p;
        inv   = ~d_p;
        last_level = level;
        check("lane_n_hi", 32'(d_n), 32'(inv));
        check("clk_hi", 32'({clk_p, clk_n}), 32'b10);
        check("level", 32'(level), 32'(m_fifo.size()));
        check("underflow", 32'(underflow_cnt), 32'(m_uf));
        @(negedge dclk); #2;
        obs_b = d_p;
        check("clk_lo", 32'({clk_p, clk_n}), 32'b01);
        exp = exp_q.pop_front();
        last_obs = {obs_a, obs_b};
        check("pins_chA", 32'(obs_a), 32'(exp[11:6]));
        check("pins_chB", 32'(obs_b), 32'(exp[5:0]));
        s_valid = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Single push, tx_en toggling with data queued, push and pop together.
        tbl[0] = '{1'b1, 1'b1, 6'h11, 6'h22, 12'h000,          1};
        tbl[1] = '{1'b1, 1'b0, 6'h00, 6'h00, ID0,              0};
        tbl[2] = '{1'b1, 1'b0, 6'h00, 6'h00, {6'h11, 6'h22},   0};
        tbl[3] = '{1'b0, 1'b1, 6'h05, 6'h06, ID1,              1};
        tbl[4] = '{1'b0, 1'b1, 6'h07, 6'h08, 12'h000,          2};
        tbl[5] = '{1'b1, 1'b0, 6'h00, 6'h00, 12'h000,          1};
        tbl[6] = '{1'b1, 1'b1, 6'h09, 6'h0A, {6'h05, 6'h06},   1};
        tbl[7] = '{1'b1, 1'b0, 6'h00, 6'h00, {6'h07, 6'h08},   0};
        tbl[8] = '{1'b1, 1'b0, 6'h00, 6'h00, {6'h09, 6'h0A},   0};
        tbl[9] = '{1'b1, 1'b0, 6'h00, 6'h00, ID2,              0};

        // Test 1: idle stream from reset, underflow counting from 0.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 6'h00, 6'h00);
        check("t1_uf", 32'(underflow_cnt), 20);

        // Test 2: 16-beat burst with tx_en=0, then drain in order.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 6'(i + 1), 6'(63 - i));
        check("t2_level_full", 32'(level), 16);
        check("t2_ready_full", 32'(s_ready), 0);
        cycle(1'b0, 1'b1, 6'h3F, 6'h3F);    // offered while full: must be dropped
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 6'h00, 6'h00);
        check("t2_level_drained", 32'(level), 0);

        // Test 3: table of hand-derived pin values around a single push.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].en, tbl[i].v, tbl[i].a, tbl[i].b);
            check($sformatf("tbl%0d_pins", i), 32'(last_obs), 32'(tbl[i].exp));
            check($sformatf("tbl%0d_level", i), 32'(last_level), 32'(tbl[i].lvl));
        end

        // Test 4: full-rate push and pop keeps level fixed and no underflow.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        check("t4_level", 32'(level), 4);
        check("t4_uf", 32'(underflow_cnt), 0);

        // Test 5: reset mid-stream with 9 queued pairs.
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 6'(i + 1), 6'(6'h30 + i));
        cycle(1'b1, 1'b0, 6'h00, 6'h00);
        cycle(1'b1, 1'b0, 6'h00, 6'h00);
        check("t5_pins_before", 32'(d_p), 32'h30);
        #1;
        rst = 1'b1;
        #1;
        check("t5_lanes_async", 32'(d_p), 0);
        check("t5_lanes_n_async", 32'(d_n), 32'h3F);
        check("t5_level_async", 32'(level), 0);
        check("t5_ready_async", 32'(s_ready), 0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 6'h00, 6'h00);
        check("t5_uf_after", 32'(underflow_cnt), 4);

`ifdef ADC_TX_RAMP_EN
        // Test 6: ramp runs 000..FFF and wraps, underflow keeps counting.
        do_reset();
        for (int i = 0; i < 4100; i++) cycle(1'b1, 1'b0, 6'h00, 6'h00);
        check("t6_uf", 32'(underflow_cnt), 4100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
